// File: rtl/tmr_vote_monitor.sv
// Majority voter and disagreement monitor for three redundant flag lanes.
// Escalates persistent disagreement to a sticky fault and emits timestamped rising-edge events.
module tmr_vote_monitor #(
  parameter int FAULT_THRESH = 3,
  parameter int RUN_W        = 4,
  parameter int CNT_W        = 8,
  parameter int TS_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             clr,
  output logic             voted,
  output logic             mismatch,
  output logic [1:0]       bad_lane,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             fault,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W-1:0]  evt_stamp,
  output logic             evt_overrun
);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  localparam logic [RUN_W-1:0] THRESH  = RUN_W'(FAULT_THRESH);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Lane index of the odd one out; three lanes always leave exactly one minority.
  function automatic logic [1:0] minority_lane(input logic a, input logic b, input logic c);
    logic [1:0] idx;
    if ((a == b) && (b == c)) begin
      idx = 2'd0;
    end else if (b == c) begin
      idx = 2'd1;
    end else if (a == c) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  logic             m_s;
  logic             mis_s;
  logic             edge_s;
  logic             slot_free_s;
  logic [1:0]       lane_s;
  logic             voted_r;
  logic             mismatch_r;
  logic [1:0]       bad_lane_r;
  logic [CNT_W-1:0] mismatch_cnt_r;
  logic             fault_r;
  logic             fault_next_s;
  logic             evt_valid_r;
  logic [TS_W-1:0]  evt_stamp_r;
  logic             evt_overrun_r;
  logic [TS_W-1:0]  ts_r;
  state_t           state_r;
  state_t           state_next_s;
  state_t           state_eff_s;
  logic [RUN_W-1:0] run_r;
  logic [RUN_W-1:0] run_next_s;
  logic [RUN_W-1:0] run_eff_s;

  assign m_s         = maj3(r0, r1, r2);
  assign mis_s       = !((r0 == r1) && (r1 == r2));
  assign lane_s      = minority_lane(r0, r1, r2);
  assign edge_s      = m_s & ~voted_r;
  assign slot_free_s = ~evt_valid_r | evt_ready;

  // Free-running timestamp, restarting at zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  // One-cycle registered vote and disagreement report.
  always_ff @(posedge clk) begin
    if (rst) begin
      voted_r    <= 1'b0;
      mismatch_r <= 1'b0;
      bad_lane_r <= 2'd0;
    end else begin
      voted_r    <= m_s;
      mismatch_r <= mis_s;
      bad_lane_r <= lane_s;
    end
  end

  // Saturating mismatch total; clr wins over a same-cycle mismatch.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      mismatch_cnt_r <= {CNT_W{1'b0}};
    end else if (mis_s && (mismatch_cnt_r != CNT_MAX)) begin
      mismatch_cnt_r <= mismatch_cnt_r + CNT_W'(1);
    end
  end

  // FSM state and run counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_OK;
      run_r   <= {RUN_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      run_r   <= run_next_s;
    end
  end

  // Next-state logic; clr restarts the evaluation from OK with an empty run.
  always_comb begin
    state_eff_s  = clr ? ST_OK : state_r;
    run_eff_s    = clr ? {RUN_W{1'b0}} : run_r;
    state_next_s = state_eff_s;
    run_next_s   = run_eff_s;
    case (state_eff_s)
      ST_OK: begin
        if (mis_s) begin
          run_next_s   = RUN_ONE;
          state_next_s = (THRESH == RUN_ONE) ? ST_FAULT : ST_SUSPECT;
        end else begin
          run_next_s   = {RUN_W{1'b0}};
          state_next_s = ST_OK;
        end
      end
      ST_SUSPECT: begin
        if (mis_s) begin
          run_next_s   = run_eff_s + RUN_ONE;
          state_next_s = ((run_eff_s + RUN_ONE) == THRESH) ? ST_FAULT : ST_SUSPECT;
        end else begin
          run_next_s   = {RUN_W{1'b0}};
          state_next_s = ST_OK;
        end
      end
      ST_FAULT: begin
        state_next_s = ST_FAULT;
        run_next_s   = run_eff_s;
      end
      default: begin
        state_next_s = ST_OK;
        run_next_s   = {RUN_W{1'b0}};
      end
    endcase
  end

  // Output decode: fault mirrors the next state so the registered flag tracks state==FAULT.
  always_comb begin
    if (state_next_s == ST_FAULT) begin
      fault_next_s = 1'b1;
    end else begin
      fault_next_s = 1'b0;
    end
  end

  // Registered fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= fault_next_s;
    end
  end

  // Single-entry event slot: load when empty or being drained, otherwise drop and flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_r   <= 1'b0;
      evt_stamp_r   <= {TS_W{1'b0}};
      evt_overrun_r <= 1'b0;
    end else begin
      if (slot_free_s) begin
        evt_valid_r <= edge_s;
        if (edge_s) begin
          evt_stamp_r <= ts_r;
        end
      end
      if (clr) begin
        evt_overrun_r <= 1'b0;
      end else if (edge_s && !slot_free_s) begin
        evt_overrun_r <= 1'b1;
      end
    end
  end

  assign voted        = voted_r;
  assign mismatch     = mismatch_r;
  assign bad_lane     = bad_lane_r;
  assign mismatch_cnt = mismatch_cnt_r;
  assign fault        = fault_r;
  assign evt_valid    = evt_valid_r;
  assign evt_stamp    = evt_stamp_r;
  assign evt_overrun  = evt_overrun_r;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Directed bench for tmr_vote_monitor (FAULT_THRESH=3, CNT_W=2 so saturation is reachable).
// Edge Ek after reset release samples ts=k-1; outputs are checked 1ns after each edge.
module tb_tmr_vote_monitor;

  localparam int CNT_W = 2;
  localparam int TS_W  = 16;

  logic             clk;
  logic             rst;
  logic             r0;
  logic             r1;
  logic             r2;
  logic             clr;
  logic             voted;
  logic             mismatch;
  logic [1:0]       bad_lane;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             fault;
  logic             evt_valid;
  logic             evt_ready;
  logic [TS_W-1:0]  evt_stamp;
  logic             evt_overrun;

  int checks;
  int errors;

  tmr_vote_monitor #(
    .FAULT_THRESH(3),
    .RUN_W(4),
    .CNT_W(CNT_W),
    .TS_W(TS_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .r0(r0),
    .r1(r1),
    .r2(r2),
    .clr(clr),
    .voted(voted),
    .mismatch(mismatch),
    .bad_lane(bad_lane),
    .mismatch_cnt(mismatch_cnt),
    .fault(fault),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_stamp(evt_stamp),
    .evt_overrun(evt_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lanes(input logic [2:0] v);
    r0 = v[0];
    r1 = v[1];
    r2 = v[2];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".voted"}, 32'(voted), 32'd0);
    chk({tag, ".mismatch"}, 32'(mismatch), 32'd0);
    chk({tag, ".bad_lane"}, 32'(bad_lane), 32'd0);
    chk({tag, ".cnt"}, 32'(mismatch_cnt), 32'd0);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
    chk({tag, ".evt_valid"}, 32'(evt_valid), 32'd0);
    chk({tag, ".evt_stamp"}, 32'(evt_stamp), 32'd0);
    chk({tag, ".overrun"}, 32'(evt_overrun), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    evt_ready = 1'b0;
    lanes(3'b000);
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Agreeing lanes from ts=2 with a ready consumer.
    evt_ready = 1'b1;
    tick();                         // E1 ts=0
    tick();                         // E2 ts=1
    lanes(3'b111);
    tick();                         // E3 ts=2
    chk("agree.voted", 32'(voted), 32'd1);
    chk("agree.evt_valid", 32'(evt_valid), 32'd1);
    chk("agree.evt_stamp", 32'(evt_stamp), 32'd2);
    chk("agree.mismatch", 32'(mismatch), 32'd0);
    chk("agree.cnt", 32'(mismatch_cnt), 32'd0);
    tick();                         // E4
    chk("agree.evt_gone", 32'(evt_valid), 32'd0);
    chk("agree.voted_hold", 32'(voted), 32'd1);

    // Single glitch on r1.
    lanes(3'b101);
    tick();                         // E5
    chk("glitch.mismatch", 32'(mismatch), 32'd1);
    chk("glitch.bad_lane", 32'(bad_lane), 32'd2);
    chk("glitch.voted", 32'(voted), 32'd1);
    chk("glitch.cnt", 32'(mismatch_cnt), 32'd1);
    chk("glitch.fault", 32'(fault), 32'd0);
    lanes(3'b111);
    tick();                         // E6
    chk("glitch.recover_mis", 32'(mismatch), 32'd0);
    chk("glitch.recover_lane", 32'(bad_lane), 32'd0);
    chk("glitch.recover_fault", 32'(fault), 32'd0);
    tick();                         // E7

    // Persistent disagreement on r2; an early fault here means the glitch run was not cleared.
    lanes(3'b011);
    tick();                         // E8
    chk("persist.s1_fault", 32'(fault), 32'd0);
    chk("persist.s1_lane", 32'(bad_lane), 32'd3);
    chk("persist.s1_cnt", 32'(mismatch_cnt), 32'd2);
    tick();                         // E9
    chk("persist.s2_fault", 32'(fault), 32'd0);
    chk("persist.s2_cnt", 32'(mismatch_cnt), 32'd3);
    tick();                         // E10
    chk("persist.s3_fault", 32'(fault), 32'd1);
    chk("persist.s3_voted", 32'(voted), 32'd1);
    lanes(3'b111);
    tick();                         // E11
    chk("persist.sticky1", 32'(fault), 32'd1);
    tick();                         // E12
    chk("persist.sticky2", 32'(fault), 32'd1);
    clr = 1'b1;
    tick();                         // E13
    clr = 1'b0;
    chk("persist.clr_fault", 32'(fault), 32'd0);
    chk("persist.clr_cnt", 32'(mismatch_cnt), 32'd0);

    // Backpressure: voted 0,1,0,1 with evt_ready low.
    evt_ready = 1'b0;
    lanes(3'b000);
    tick();                         // E14 ts=13
    lanes(3'b111);
    tick();                         // E15 ts=14
    chk("bp.first_valid", 32'(evt_valid), 32'd1);
    chk("bp.first_stamp", 32'(evt_stamp), 32'd14);
    chk("bp.no_overrun", 32'(evt_overrun), 32'd0);
    lanes(3'b000);
    tick();                         // E16 ts=15
    chk("bp.hold_stamp", 32'(evt_stamp), 32'd14);
    lanes(3'b111);
    tick();                         // E17 ts=16, edge dropped
    chk("bp.overrun", 32'(evt_overrun), 32'd1);
    chk("bp.kept_valid", 32'(evt_valid), 32'd1);
    chk("bp.kept_stamp", 32'(evt_stamp), 32'd14);
    evt_ready = 1'b1;
    tick();                         // E18 first event accepted
    chk("bp.drained", 32'(evt_valid), 32'd0);
    chk("bp.overrun_sticky", 32'(evt_overrun), 32'd1);
    clr = 1'b1;
    tick();                         // E19
    clr = 1'b0;
    chk("bp.clr_overrun", 32'(evt_overrun), 32'd0);

    // Accept and new edge in the same cycle.
    evt_ready = 1'b0;
    lanes(3'b000);
    tick();                         // E20 ts=19
    lanes(3'b111);
    tick();                         // E21 ts=20
    chk("acc.first_stamp", 32'(evt_stamp), 32'd20);
    lanes(3'b000);
    tick();                         // E22 ts=21
    evt_ready = 1'b1;
    lanes(3'b111);
    tick();                         // E23 ts=22
    chk("acc.reload_valid", 32'(evt_valid), 32'd1);
    chk("acc.reload_stamp", 32'(evt_stamp), 32'd22);
    chk("acc.no_overrun", 32'(evt_overrun), 32'd0);
    tick();                         // E24
    chk("acc.drained", 32'(evt_valid), 32'd0);

    // Saturation with continuous mismatch, then reset with an event pending.
    evt_ready = 1'b0;
    lanes(3'b001);
    tick();                         // E25 ts=24
    chk("sat.c1", 32'(mismatch_cnt), 32'd1);
    chk("sat.lane_r0", 32'(bad_lane), 32'd1);
    chk("sat.voted0", 32'(voted), 32'd0);
    tick();                         // E26
    chk("sat.c2", 32'(mismatch_cnt), 32'd2);
    tick();                         // E27
    chk("sat.c3", 32'(mismatch_cnt), 32'd3);
    chk("sat.fault", 32'(fault), 32'd1);
    lanes(3'b110);
    tick();                         // E28 ts=27, edge while in FAULT
    chk("sat.c4", 32'(mismatch_cnt), 32'd3);
    chk("sat.evt_valid", 32'(evt_valid), 32'd1);
    chk("sat.evt_stamp", 32'(evt_stamp), 32'd27);
    chk("sat.lane_r0b", 32'(bad_lane), 32'd1);
    tick();                         // E29
    chk("sat.c5", 32'(mismatch_cnt), 32'd3);
    tick();                         // E30
    rst = 1'b1;
    tick();                         // E31
    chk_all_zero("midrst");
    rst       = 1'b0;
    evt_ready = 1'b1;
    lanes(3'b111);
    tick();                         // first sample after reset, ts=0
    chk("midrst.evt_valid", 32'(evt_valid), 32'd1);
    chk("midrst.ts_restart", 32'(evt_stamp), 32'd0);
    chk("midrst.mismatch", 32'(mismatch), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
